mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage load/store sequencer between the pipeline and a single-port data memory with a valid/ready handshake.
- Turns a byte/half/word access into word-aligned memory beats with byte enables and lane-shifted write data.
- Returns sign- or zero-extended load data.
- Stalls the pipeline until the access completes. Misaligned accesses are split into two beats, or faulted (see Optional Feature).

Parameters:
- DATA_WIDTH, 32, data bus and register width; multiple of 8, minimum 16.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- MemReqM  in  1  valid load/store in MEM stage.
- MemWriteM  in  1  1 = store, 0 = load.
- SizeM  in  2  00 word, 01 byte, 10 half; 11 reserved, treated as word.
- LoadUnsignedM  in  1  zero-extend load result.
- AddrM  in  ADDR_WIDTH  byte address.
- WriteDataM  in  DATA_WIDTH  store data, right-justified.
- StallM  out  1  hold the pipeline.
- DoneM  out  1  one-cycle completion pulse.
- ReadDataM  out  DATA_WIDTH  extended load data, valid when DoneM=1.
- MisalignFaultM  out  1  misaligned access rejected; valid with DoneM.
- DmemReq  out  1  beat request.
- DmemWe  out  1  beat is a write.
- DmemAddr  out  ADDR_WIDTH  word-aligned beat address.
- DmemBe  out  DATA_WIDTH/8  byte enables.
- DmemWdata  out  DATA_WIDTH  lane-shifted write data.
- DmemReady  in  1  beat accepted when DmemReq & DmemReady.
- DmemRvalid  in  1  read data return, one per read beat, in order.
- DmemRdata  in  DATA_WIDTH  read data.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. Capture registers cleared. Any in-flight beat is abandoned.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE: on MemReqM=1, latch address, size, write flag, data and unsigned flag, then go to REQ0.
- REQ0: DmemReq=1, DmemAddr = aligned address. On DmemReady:
  - read → WAIT0;
  - write with a second beat needed → REQ1;
  - otherwise → DONE.
- WAIT0: on DmemRvalid, capture the low word, then go to REQ1 if split, else DONE.
- REQ1: DmemAddr = aligned address + DATA_WIDTH/8. On DmemReady: read → WAIT1, write → DONE.
- WAIT1: on DmemRvalid, capture the high word, then go to DONE.
- DONE: DoneM=1, then go to IDLE.
- StallM = MemReqM & (state != DONE), combinational. The pipeline holds all M inputs stable while StallM=1.
- Minimum latency, aligned store: 3 cycles (IDLE, REQ0 accepted, DONE).
- Minimum latency, aligned load: 4 cycles.
- All Dmem outputs are registered/state-decoded. DmemReq, DmemAddr, DmemBe and DmemWdata stay stable until DmemReady.
- Lane rules, with off = addr mod (DATA_WIDTH/8) and n = bytes in the access:
  - mask = ((1<<n)-1) << off over 2·DATA_WIDTH/8 bits. Beat 0 uses the low half, beat 1 the high half.
  - Wdata is {0, data} << 8·off, over 2·DATA_WIDTH bits, split the same way.
  - Split is needed when off + n > DATA_WIDTH/8.
  - Load result = ({hi, lo} >> 8·off) truncated to n bytes, then extended. Sign-extend unless LoadUnsignedM=1. Word loads are unaffected by extension.
- ReadDataM is registered and holds its value until the next DONE. It is 0 for stores.
- Simultaneous DmemReady and DmemRvalid in a WAIT state: only DmemRvalid is meaningful there; DmemReady is ignored outside REQ states.
- A DmemRvalid arriving outside a WAIT state is ignored.
- A MemReqM dropping mid-access is a protocol violation; the sequence still completes.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are split as above, and MisalignFaultM is tied to 0.
- Undefined: a misaligned access goes IDLE → DONE with no Dmem traffic. MisalignFaultM=1 and ReadDataM=0 in that DONE cycle. REQ1/WAIT1 are unreachable and may be removed.

Decomposition:
- Package mem_ctrl_pkg:
  - state enum mem_state_t;
  - size constants SIZE_WORD=2'b00, SIZE_BYTE=2'b01, SIZE_HALF=2'b10;
  - function size_bytes().
- Sub-module mem_lane_align, combinational: mask/wdata shift, split detect, read extract and extend.

Test Plan:
- Aligned SW, addr 0x100, data 0xDEADBEEF, DmemReady=1 → one beat at 0x100, Be=1111, Wdata=0xDEADBEEF, DoneM in cycle 3, StallM high for cycles 1–2.
- SB, addr 0x103, data 0x000000AB → Be=1000, Wdata=0xAB000000, single beat.
- LB, addr 0x202, Rdata=0x00800000, signed → ReadDataM=0xFFFFFF80; same access with LoadUnsignedM=1 → 0x00000080.
- LW, addr 0x301, split enabled, Rdata 0x44332211 then 0x88776655 → beats at 0x300 (Be 1110) and 0x304 (Be 0001), ReadDataM=0x55443322; with the macro undefined → no DmemReq, MisalignFaultM=1.
- DmemReady held low 5 cycles in REQ0 → Dmem outputs stable, StallM=1 throughout, DoneM only after acceptance.
- rst_n pulsed low in WAIT0 → immediate IDLE, all outputs 0; a later DmemRvalid is ignored.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer.
//   mem_state_t : sequencer FSM states
//   SIZE_*      : encodings of the access-size field (2'b11 is treated as word)
//   size_bytes  : number of bytes touched by an access of a given size
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_DONE  = 3'd5
    } mem_state_t;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;

    function automatic int size_bytes(input logic [1:0] size, input int word_bytes);
        case (size)
            SIZE_BYTE: return 1;
            SIZE_HALF: return 2;
            default:   return word_bytes;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for one load/store access.
// Ports:
//   off    : in  byte offset of the access inside a data word
//   size   : in  access size code
//   uns    : in  zero-extend load result when 1
//   wdata  : in  right-justified store data
//   rd_lo  : in  first (lower-address) read word
//   rd_hi  : in  second (higher-address) read word
//   be_lo/be_hi : out byte enables for beat 0 / beat 1
//   wd_lo/wd_hi : out lane-shifted write data for beat 0 / beat 1
//   split  : out access straddles a word boundary
//   rd_ext : out extracted and extended load data
module mem_lane_align
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int NB = DATA_WIDTH / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic [OFFW-1:0]       off,
    input  logic [1:0]            size,
    input  logic                  uns,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rd_lo,
    input  logic [DATA_WIDTH-1:0] rd_hi,
    output logic [NB-1:0]         be_lo,
    output logic [NB-1:0]         be_hi,
    output logic [DATA_WIDTH-1:0] wd_lo,
    output logic [DATA_WIDTH-1:0] wd_hi,
    output logic                  split,
    output logic [DATA_WIDTH-1:0] rd_ext
);

    int                      n;
    logic [2*NB-1:0]         mask;
    logic [2*DATA_WIDTH-1:0] wide_wd;
    logic [DATA_WIDTH-1:0]   wide_rd;

    always_comb begin
        n     = size_bytes(size, NB);
        split = (int'(off) + n) > NB;

        // Enables span two words so a straddling access falls into beat 1.
        mask = '0;
        for (int i = 0; i < 2 * NB; i++) begin
            mask[i] = (i >= int'(off)) && (i < int'(off) + n);
        end

        wide_wd = {{DATA_WIDTH{1'b0}}, wdata} << (8 * int'(off));

        // Only the low word of the shifted pair can hold the requested bytes.
        wide_rd = DATA_WIDTH'({rd_hi, rd_lo} >> (8 * int'(off)));

        rd_ext = wide_rd;
        if (size == SIZE_BYTE) begin
            for (int i = 8; i < DATA_WIDTH; i++) rd_ext[i] = ~uns & wide_rd[7];
        end else if (size == SIZE_HALF) begin
            for (int i = 16; i < DATA_WIDTH; i++) rd_ext[i] = ~uns & wide_rd[15];
        end
    end

    assign be_lo = mask[NB-1:0];
    assign be_hi = mask[2*NB-1:NB];
    assign wd_lo = wide_wd[DATA_WIDTH-1:0];
    assign wd_hi = wide_wd[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer in front of a single-port data memory.
// Breaks a byte/half/word access into word-aligned beats, stalls the
// pipeline until it completes and returns extended load data.
//
// Configuration macro: MEM_ACCESS_MISALIGN_SPLIT_EN
//   defined   : accesses crossing a word boundary become two beats
//   undefined : such accesses complete at once with MisalignFaultM=1, no beats
//
// Handshake: a beat transfers in a cycle where DmemReq & DmemReady; the beat
// outputs hold steady until then. Each read beat gets exactly one DmemRvalid,
// in order, no earlier than the cycle after it was accepted.
//
// Ports: pipeline side MemReqM/MemWriteM/SizeM/LoadUnsignedM/AddrM/WriteDataM
// in, StallM/DoneM/ReadDataM/MisalignFaultM out; memory side DmemReq/DmemWe/
// DmemAddr/DmemBe/DmemWdata out, DmemReady/DmemRvalid/DmemRdata in;
// dbg_state exposes the FSM state.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    MemReqM,
    input  logic                    MemWriteM,
    input  logic [1:0]              SizeM,
    input  logic                    LoadUnsignedM,
    input  logic [ADDR_WIDTH-1:0]   AddrM,
    input  logic [DATA_WIDTH-1:0]   WriteDataM,
    output logic                    StallM,
    output logic                    DoneM,
    output logic [DATA_WIDTH-1:0]   ReadDataM,
    output logic                    MisalignFaultM,
    output logic                    DmemReq,
    output logic                    DmemWe,
    output logic [ADDR_WIDTH-1:0]   DmemAddr,
    output logic [DATA_WIDTH/8-1:0] DmemBe,
    output logic [DATA_WIDTH-1:0]   DmemWdata,
    input  logic                    DmemReady,
    input  logic                    DmemRvalid,
    input  logic [DATA_WIDTH-1:0]   DmemRdata,
    output logic [2:0]              dbg_state
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);

    mem_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  we_q, uns_q;
    logic [DATA_WIDTH-1:0] wdata_q, lo_q, hi_q;

    logic                  in_idle, beat1, split, fault_now, enter_done;
    logic [OFFW-1:0]       off_sel;
    logic [1:0]            size_sel;
    logic [DATA_WIDTH-1:0] rd_lo_sel, rd_hi_sel, rd_ext, wd_lo, wd_hi;
    logic [NB-1:0]         be_lo, be_hi;
    logic [ADDR_WIDTH-1:0] beat_addr;

    assign in_idle = (state == ST_IDLE);
    assign beat1   = (state == ST_REQ1);

    // In IDLE the aligner looks at the incoming access so the split/fault
    // decision is ready in the cycle the request is latched.
    assign off_sel  = in_idle ? AddrM[OFFW-1:0] : addr_q[OFFW-1:0];
    assign size_sel = in_idle ? SizeM : size_q;

    // Feed the word arriving this cycle straight through so ReadDataM can be
    // registered on the same edge that enters DONE.
    assign rd_lo_sel = (state == ST_WAIT0) ? DmemRdata : lo_q;
    assign rd_hi_sel = (state == ST_WAIT1) ? DmemRdata : hi_q;

    mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .off    (off_sel),
        .size   (size_sel),
        .uns    (uns_q),
        .wdata  (wdata_q),
        .rd_lo  (rd_lo_sel),
        .rd_hi  (rd_hi_sel),
        .be_lo  (be_lo),
        .be_hi  (be_hi),
        .wd_lo  (wd_lo),
        .wd_hi  (wd_hi),
        .split  (split),
        .rd_ext (rd_ext)
    );

`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
    assign fault_now      = 1'b0;
    assign MisalignFaultM = 1'b0;
`else
    logic fault_q;
    assign fault_now      = in_idle & MemReqM & split;
    assign MisalignFaultM = fault_q & (state == ST_DONE);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (MemReqM) state_nxt = fault_now ? ST_DONE : ST_REQ0;
            ST_REQ0:  if (DmemReady) begin
                          if (!we_q)      state_nxt = ST_WAIT0;
                          else if (split) state_nxt = ST_REQ1;
                          else            state_nxt = ST_DONE;
                      end
            ST_WAIT0: if (DmemRvalid) state_nxt = split ? ST_REQ1 : ST_DONE;
            ST_REQ1:  if (DmemReady) state_nxt = we_q ? ST_DONE : ST_WAIT1;
            ST_WAIT1: if (DmemRvalid) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign enter_done = (state_nxt == ST_DONE) && (state != ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            wdata_q   <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            ReadDataM <= '0;
`ifndef MEM_ACCESS_MISALIGN_SPLIT_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (in_idle && MemReqM) begin
                addr_q  <= AddrM;
                size_q  <= SizeM;
                we_q    <= MemWriteM;
                uns_q   <= LoadUnsignedM;
                wdata_q <= WriteDataM;
            end
            if (state == ST_WAIT0 && DmemRvalid) lo_q <= DmemRdata;
            if (state == ST_WAIT1 && DmemRvalid) hi_q <= DmemRdata;
            if (enter_done) begin
                // Stores and rejected accesses report zero load data.
                ReadDataM <= (we_q || fault_now) ? '0 : rd_ext;
`ifndef MEM_ACCESS_MISALIGN_SPLIT_EN
                fault_q   <= fault_now;
`endif
            end
        end
    end

    assign beat_addr = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}}
                     + (beat1 ? ADDR_WIDTH'(NB) : '0);

    assign DmemReq   = (state == ST_REQ0) || (state == ST_REQ1);
    assign DmemWe    = DmemReq & we_q;
    assign DmemAddr  = DmemReq ? beat_addr : '0;
    assign DmemBe    = DmemReq ? (beat1 ? be_hi : be_lo) : '0;
    assign DmemWdata = DmemReq ? (beat1 ? wd_hi : wd_lo) : '0;

    assign DoneM     = (state == ST_DONE);
    assign StallM    = MemReqM & (state != ST_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases plus randomized accesses against
// a byte-addressed reference memory, with a memory responder that checks beats.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          MemReqM, MemWriteM, LoadUnsignedM;
    logic [1:0]    SizeM;
    logic [AW-1:0] AddrM;
    logic [DW-1:0] WriteDataM;
    logic          StallM, DoneM, MisalignFaultM;
    logic [DW-1:0] ReadDataM;
    logic          DmemReq, DmemWe, DmemReady, DmemRvalid;
    logic [AW-1:0] DmemAddr;
    logic [3:0]    DmemBe;
    logic [DW-1:0] DmemWdata, DmemRdata;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemReqM(MemReqM), .MemWriteM(MemWriteM), .SizeM(SizeM),
        .LoadUnsignedM(LoadUnsignedM), .AddrM(AddrM), .WriteDataM(WriteDataM),
        .StallM(StallM), .DoneM(DoneM), .ReadDataM(ReadDataM),
        .MisalignFaultM(MisalignFaultM),
        .DmemReq(DmemReq), .DmemWe(DmemWe), .DmemAddr(DmemAddr), .DmemBe(DmemBe),
        .DmemWdata(DmemWdata), .DmemReady(DmemReady), .DmemRvalid(DmemRvalid),
        .DmemRdata(DmemRdata), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0]   exp_q[$];        // {fault, read data} per completed access
    logic [68:0]   exp_beat_q[$];   // {we, addr, be, wdata} per memory beat
    logic [31:0]   rd_pend_q[$];
    logic [7:0]    dmem    [logic [31:0]];
    logic [7:0]    ref_mem [logic [31:0]];
    bit            fast_mode, hold_rvalid;
    int            force_lo, rd_delay;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] dmem_byte(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            dmem[a + 32'(i)]    = w[8*i +: 8];
            ref_mem[a + 32'(i)] = w[8*i +: 8];
        end
    endtask

    // Memory responder: decides DmemReady each cycle, checks accepted beats
    // and returns read data later, one word per accepted read beat.
    initial begin : responder
        logic [68:0] cur, prev;
        logic [31:0] w;
        bit          prev_pending;
        prev_pending = 0;
        prev = '0;
        DmemReady = 1'b0; DmemRvalid = 1'b0; DmemRdata = '0; rd_delay = 0;
        forever begin
            @(posedge clk); #1;
            DmemRvalid = 1'b0;
            DmemRdata  = $urandom();
            if (rd_pend_q.size() > 0 && !hold_rvalid) begin
                if (rd_delay > 0) rd_delay--;
                else begin
                    w = rd_pend_q.pop_front();
                    for (int i = 0; i < 4; i++) DmemRdata[8*i +: 8] = dmem_byte(w + 32'(i));
                    DmemRvalid = 1'b1;
                end
            end
            cur = {DmemWe, DmemAddr, DmemBe, DmemWdata};
            if (prev_pending && DmemReq) check("dmem_stable", cur, prev);
            if (DmemReq && force_lo > 0) begin
                DmemReady = 1'b0;
                force_lo--;
            end else begin
                DmemReady = fast_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            prev_pending = 0;
            if (DmemReq && rst_n) begin
                if (!DmemReady) begin
                    prev_pending = 1;
                    prev = cur;
                end else if (exp_beat_q.size() == 0) begin
                    check("beat_unexpected", {DmemWe, DmemAddr}, '0);
                end else begin
                    logic [68:0] eb;
                    eb = exp_beat_q.pop_front();
                    check("beat_hdr", cur[68:32], eb[68:32]);
                    if (eb[68]) check("beat_wdata", cur[31:0], eb[31:0]);
                    if (DmemWe) begin
                        for (int i = 0; i < 4; i++)
                            if (DmemBe[i]) dmem[DmemAddr + 32'(i)] = DmemWdata[8*i +: 8];
                    end else begin
                        rd_pend_q.push_back(DmemAddr);
                        rd_delay = fast_mode ? 0 : int'($urandom_range(0, 2));
                    end
                end
            end
        end
    end

    // Completion monitor: every DoneM pops one expected response.
    initial begin : monitor
        logic [32:0] e;
        forever begin
            @(posedge clk); #1;
            if (rst_n && DoneM) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", DoneM, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("read_data", ReadDataM, e[31:0]);
                    check("misalign_fault", MisalignFaultM, e[32]);
                end
            end
        end
    end

    // Issues one access, pushes its expected beats and result, and waits for
    // completion. lat counts cycles from request to the DoneM cycle inclusive.
    task automatic do_access(input bit we, input logic [1:0] size, input bit uns,
                             input logic [31:0] addr, input logic [31:0] data,
                             output int lat);
        int          n, off;
        bit          split, fault;
        logic [63:0] wd;
        logic [7:0]  m8;
        logic [31:0] val, wa;
        n     = (size == SIZE_BYTE) ? 1 : (size == SIZE_HALF) ? 2 : 4;
        off   = int'(addr[1:0]);
        split = (off + n) > 4;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
        fault = 0;
`else
        fault = split;
`endif
        val = '0;
        if (fault) begin
            exp_q.push_back({1'b1, 32'h0});
        end else begin
            wd = {32'h0, data} << (8 * off);
            m8 = 8'(((1 << n) - 1) << off);
            wa = {addr[31:2], 2'b00};
            exp_beat_q.push_back({we, wa, m8[3:0], wd[31:0]});
            if (split) exp_beat_q.push_back({we, wa + 32'd4, m8[7:4], wd[63:32]});
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = data[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) val[8*i +: 8] = ref_byte(addr + 32'(i));
                if (!uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
            end
            exp_q.push_back({1'b0, we ? 32'h0 : val});
        end

        MemReqM = 1'b1; MemWriteM = we; SizeM = size; LoadUnsignedM = uns;
        AddrM = addr; WriteDataM = data;
        #1;
        check("stall_start", StallM, 1'b1);
        lat = 1;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (DoneM) break;
            check("stall_hold", StallM, 1'b1);
            if (lat > 200) begin
                check("access_timeout", lat, 0);
                finish_test();
            end
        end
        check("stall_done", StallM, 1'b0);
        MemReqM = 1'b0;
        MemWriteM = 1'($urandom()); WriteDataM = $urandom(); AddrM = $urandom();
        repeat (1 + (fast_mode ? 0 : int'($urandom_range(0, 1)))) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, StallM, 1'b0);
        check({tag, "_done"}, DoneM, 1'b0);
        check({tag, "_rdata"}, ReadDataM, '0);
        check({tag, "_fault"}, MisalignFaultM, 1'b0);
        check({tag, "_req"}, DmemReq, 1'b0);
        check({tag, "_we"}, DmemWe, 1'b0);
        check({tag, "_addr"}, DmemAddr, '0);
        check({tag, "_be"}, DmemBe, '0);
        check({tag, "_wdata"}, DmemWdata, '0);
    endtask

    initial begin : watchdog
        #500000;
        check("global_timeout", 1'b1, 1'b0);
        finish_test();
    end

    initial begin : main
        int lat;
        bit we, uns;
        logic [1:0] size;
        MemReqM = 0; MemWriteM = 0; SizeM = 0; LoadUnsignedM = 0; AddrM = 0; WriteDataM = 0;
        fast_mode = 1; hold_rvalid = 0; force_lo = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases with an always-ready memory.
        do_access(1, SIZE_WORD, 0, 32'h100, 32'hDEAD_BEEF, lat);
        check("lat_sw_aligned", lat, 3);
        do_access(1, SIZE_BYTE, 0, 32'h103, 32'h0000_00AB, lat);
        check("lat_sb", lat, 3);
        preload(32'h200, 32'h0080_0000);
        do_access(0, SIZE_BYTE, 0, 32'h202, 32'h0, lat);
        check("lat_lb_aligned", lat, 4);
        do_access(0, SIZE_BYTE, 1, 32'h202, 32'h0, lat);
        preload(32'h300, 32'h4433_2211);
        preload(32'h304, 32'h8877_6655);
        do_access(0, SIZE_WORD, 0, 32'h301, 32'h0, lat);
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
        check("lat_lw_split", lat, 6);
`else
        check("lat_lw_fault", lat, 2);
`endif
        do_access(0, SIZE_HALF, 0, 32'h302, 32'h0, lat);

        force_lo = 5;
        do_access(1, SIZE_WORD, 0, 32'h500, 32'h1234_5678, lat);
        check("lat_ready_held_low", lat, 8);

        // Reset while waiting for read data; the late Rvalid must be ignored.
        hold_rvalid = 1;
        exp_beat_q.push_back({1'b0, 32'h400, 4'hF, 32'h0});
        MemReqM = 1; MemWriteM = 0; SizeM = SIZE_WORD; LoadUnsignedM = 0; AddrM = 32'h400;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (dbg_state != ST_WAIT0 && lat < 20);
        check("reach_wait0", dbg_state, ST_WAIT0);
        MemReqM = 0;
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        hold_rvalid = 0;
        repeat (6) begin
            @(posedge clk); #1;
            check("post_reset_idle", {DoneM, DmemReq}, 2'b00);
        end
        check("late_rvalid_sent", rd_pend_q.size(), 0);

        // Randomized traffic with random ready and read-return delays.
        fast_mode = 0;
        repeat (150) begin
            we   = 1'($urandom());
            uns  = 1'($urandom());
            size = 2'($urandom_range(0, 3));
            do_access(we, size, uns, 32'($urandom_range(0, 63)), $urandom(), lat);
        end

        repeat (5) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("beat_q_drained", exp_beat_q.size(), 0);
        finish_test();
    end

endmodule
